// File: rtl/key_scan_ctrl.sv
// Debounce controller for a bank of active-low keys sharing one debounce timer.
// A round-robin arbiter grants the timer; outputs are debounced level, press and long-press pulses.
module key_scan_ctrl #(
  parameter int N_KEYS     = 4,
  parameter int IDX_W      = 2,
  parameter int DEB_CYCLES = 1048575,
  parameter int CNT_W      = 20,
  parameter int LONG_TICKS = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rstn,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_long,
  output logic              busy,
  output logic [IDX_W-1:0]  active_idx
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TIMING  = 2'd1,
    ST_CONFIRM = 2'd2
  } state_t;

  localparam int               IDX_W1   = IDX_W + 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [7:0]       LONG_MAX = 8'(LONG_TICKS);
  localparam logic [IDX_W:0]   N_WIDE   = IDX_W1'(N_KEYS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_KEYS - 1);

  state_t            state_r, state_nxt_s;
  logic [N_KEYS-1:0] sync1_r, sync2_r, key_state_r, key_press_r, key_long_r, pending_r;
  logic [N_KEYS-1:0] pend_nxt_s, ks_nxt_s, press_nxt_s, long_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s, presc_r;
  logic [IDX_W-1:0]  active_idx_r, active_nxt_s, rr_ptr_r, rr_nxt_s, rr_wrap_s, grant_idx_s;
  logic [IDX_W:0]    cand_s;
  logic              grant_vld_s, abort_s, tick_s, done_s, confirm_s, busy_r, busy_nxt_s;
  logic [7:0]        hold_r     [N_KEYS];
  logic [7:0]        hold_nxt_s [N_KEYS];

  assign abort_s    = (sync2_r[active_idx_r] == key_state_r[active_idx_r]);
  assign rr_wrap_s  = (active_idx_r == IDX_LAST) ? {IDX_W{1'b0}} : active_idx_r + IDX_W'(1);
  assign tick_s     = (presc_r == DEB_LAST);
  assign busy_nxt_s = (state_nxt_s != ST_IDLE);

  assign key_state  = key_state_r;
  assign key_press  = key_press_r;
  assign key_long   = key_long_r;
  assign busy       = busy_r;
  assign active_idx = active_idx_r;

  // Round-robin search: walk downward so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = {IDX_W{1'b0}};
    cand_s      = {IDX_W1{1'b0}};
    for (int k = N_KEYS - 1; k >= 0; k--) begin
      cand_s = {1'b0, rr_ptr_r} + IDX_W1'(k);
      if (cand_s >= N_WIDE) begin
        cand_s = cand_s - N_WIDE;
      end else begin
        cand_s = cand_s;
      end
      if (pending_r[cand_s[IDX_W-1:0]]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand_s[IDX_W-1:0];
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a bounce back in TIMING takes priority over the timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:    state_nxt_s = grant_vld_s ? ST_TIMING : ST_IDLE;
      ST_TIMING: begin
        if (abort_s) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == DEB_LAST) begin
          state_nxt_s = ST_CONFIRM;
        end else begin
          state_nxt_s = ST_TIMING;
        end
      end
      ST_CONFIRM: state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: timer, ownership, pointer and per-key level/pending updates.
  always_comb begin
    cnt_nxt_s    = cnt_r;
    active_nxt_s = active_idx_r;
    rr_nxt_s     = rr_ptr_r;
    done_s       = 1'b0;
    confirm_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        active_nxt_s = grant_vld_s ? grant_idx_s : active_idx_r;
        cnt_nxt_s    = grant_vld_s ? {CNT_W{1'b0}} : cnt_r;
      end
      ST_TIMING: begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
        done_s    = abort_s;
        rr_nxt_s  = abort_s ? rr_wrap_s : rr_ptr_r;
      end
      ST_CONFIRM: begin
        done_s    = 1'b1;
        confirm_s = 1'b1;
        rr_nxt_s  = rr_wrap_s;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
    for (int i = 0; i < N_KEYS; i++) begin
      pend_nxt_s[i]  = (done_s && (active_idx_r == IDX_W'(i))) ? 1'b0
                     : (pending_r[i] | (sync2_r[i] ^ key_state_r[i]));
      ks_nxt_s[i]    = (confirm_s && (active_idx_r == IDX_W'(i))) ? sync2_r[i] : key_state_r[i];
      press_nxt_s[i] = confirm_s && (active_idx_r == IDX_W'(i)) && !sync2_r[i];
    end
  end

  // Hold counters: count prescaler ticks while pressed, saturating at LONG_TICKS.
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      long_nxt_s[i] = 1'b0;
      if (key_state_r[i]) begin
        hold_nxt_s[i] = 8'd0;
      end else if (tick_s && (hold_r[i] != LONG_MAX)) begin
        hold_nxt_s[i] = hold_r[i] + 8'd1;
        long_nxt_s[i] = (hold_r[i] == (LONG_MAX - 8'd1));
      end else begin
        hold_nxt_s[i] = hold_r[i];
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync1_r      <= {N_KEYS{1'b1}};
      sync2_r      <= {N_KEYS{1'b1}};
      key_state_r  <= {N_KEYS{1'b1}};
      key_press_r  <= {N_KEYS{1'b0}};
      key_long_r   <= {N_KEYS{1'b0}};
      pending_r    <= {N_KEYS{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      presc_r      <= {CNT_W{1'b0}};
      active_idx_r <= {IDX_W{1'b0}};
      rr_ptr_r     <= {IDX_W{1'b0}};
      busy_r       <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
        hold_r[i] <= 8'd0;
      end
    end else begin
      sync1_r      <= key_in;
      sync2_r      <= sync1_r;
      key_state_r  <= ks_nxt_s;
      key_press_r  <= press_nxt_s;
      key_long_r   <= long_nxt_s;
      pending_r    <= pend_nxt_s;
      cnt_r        <= cnt_nxt_s;
      presc_r      <= tick_s ? {CNT_W{1'b0}} : presc_r + CNT_W'(1);
      active_idx_r <= active_nxt_s;
      rr_ptr_r     <= rr_nxt_s;
      busy_r       <= busy_nxt_s;
      for (int i = 0; i < N_KEYS; i++) begin
        hold_r[i] <= hold_nxt_s[i];
      end
    end
  end

endmodule
